awaiba_frame_tx: RTL and testbench

- Transmit-side counterpart of the Awaiba capture path.
- Takes 13-bit pixel words from the system on a valid/ready stream and drives them onto the connector-side valid/ready interface as framed output: LINES lines of LINE_LEN words, with a GAP-cycle idle between lines.
- A frame starts on a system sync pulse.
- Used for sensor emulation and loopback of the capture chain.
- Single clock domain (system clock, 125 MHz).

---
 rtl/awaiba_pkg.sv | 18 +
 rtl/awaiba_out_reg.sv | 38 +++
 rtl/awaiba_frame_tx.sv | 134 +++++++++++++
 tb/tb_awaiba_frame_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/awaiba_pkg.sv
// Shared definitions for the Awaiba capture/transmit blocks.
// Holds the default pixel word width, the default frame geometry and the
// framing FSM state encoding.
package awaiba_pkg;

  localparam int unsigned DW           = 13;
  localparam int unsigned DEF_LINE_LEN = 250;
  localparam int unsigned DEF_LINES    = 250;
  localparam int unsigned DEF_GAP      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/awaiba_out_reg.sv
// One-entry output register with a valid/ready handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         write in_data this cycle (caller only asserts when space_c=1)
//   in_data      word to hold
//   out_ready    downstream accepts out_data
//   out_data     held word, stable while out_valid=1 and out_ready=0
//   out_valid    held word is valid
//   space_c      register can take a word this cycle (combinational on out_ready)
module awaiba_out_reg #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         space_c
);

  // Empty, or emptying this cycle: allows a reload on the same edge.
  assign space_c = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/awaiba_frame_tx.sv
// Awaiba frame transmitter: forwards system pixel words to the connector
// interface as LINES lines of LINE_LEN words with GAP idle cycles between
// lines. A frame starts on sync (level-sampled) while idle.
// Optional build macro AWAIBA_TX_PATTERN_EN: an internal pattern
// (line_cnt + load_cnt) replaces data_in/valid_in.
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   sync                 frame start request
//   data_in, valid_in    system word stream
//   ready_out            block accepts data_in this cycle (combinational on ready)
//   data, valid, ready   connector word stream
//   busy                 frame in progress
//   frame_done           one-cycle pulse once the frame has completed
module awaiba_frame_tx #(
  parameter int unsigned DW       = awaiba_pkg::DW,
  parameter int unsigned LINE_LEN = awaiba_pkg::DEF_LINE_LEN,
  parameter int unsigned LINES    = awaiba_pkg::DEF_LINES,
  parameter int unsigned GAP      = awaiba_pkg::DEF_GAP
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sync,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  output logic          ready_out,
  output logic [DW-1:0] data,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          frame_done
);
  import awaiba_pkg::*;

  localparam int unsigned CW = $clog2(LINE_LEN + 1);
  localparam int unsigned LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned GW = $clog2(GAP + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] load_cnt, out_cnt;
  logic [LW-1:0] line_cnt;
  logic [GW-1:0] gap_cnt;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          space_c, load, out_xfer, line_end, gap_end, last_line;

  // Word source: external stream or internal test pattern.
`ifdef AWAIBA_TX_PATTERN_EN
  logic unused_in;
  assign unused_in = ^{data_in, valid_in};
  assign src_data  = DW'(32'(line_cnt) + 32'(load_cnt));
  assign src_valid = 1'b1;
`else
  assign src_data  = data_in;
  assign src_valid = valid_in;
`endif

  assign ready_out = (state == ST_LINE) && (load_cnt < CW'(LINE_LEN)) && space_c;
  assign load      = src_valid && ready_out;
  assign out_xfer  = valid && ready;
  assign line_end  = out_xfer && (out_cnt == CW'(LINE_LEN - 1));
  assign gap_end   = (gap_cnt == GW'(GAP - 1));
  assign last_line = (line_cnt == LW'(LINES - 1));

  awaiba_out_reg #(.W(DW)) u_out_reg (
    .clk       (clk),
    .rst_n     (reset_n),
    .load      (load),
    .in_data   (src_data),
    .out_ready (ready),
    .out_data  (data),
    .out_valid (valid),
    .space_c   (space_c)
  );

  // State register; busy/frame_done registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state_nxt == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sync)     state_nxt = ST_LINE;
      ST_LINE: if (line_end) state_nxt = ST_GAP;
      ST_GAP:  if (gap_end)  state_nxt = last_line ? ST_DONE : ST_LINE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Pixel, line and gap counters; word counters clear on every LINE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt <= '0;
      out_cnt  <= '0;
      line_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync) begin
            load_cnt <= '0;
            out_cnt  <= '0;
            line_cnt <= '0;
          end
        end
        ST_LINE: begin
          gap_cnt <= '0;
          if (load)     load_cnt <= load_cnt + CW'(1);
          if (out_xfer) out_cnt  <= out_cnt + CW'(1);
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_end && !last_line) begin
            line_cnt <= line_cnt + LW'(1);
            load_cnt <= '0;
            out_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_awaiba_frame_tx.sv
// Bench for awaiba_frame_tx with LINE_LEN=4, LINES=2, GAP=3.
module tb_awaiba_frame_tx;
  localparam int unsigned DW = 13;
  localparam int unsigned LL = 4;
  localparam int unsigned NL = 2;
  localparam int unsigned G  = 3;
`ifdef AWAIBA_TX_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sync = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data;
  logic          ready_out, valid, busy, frame_done;

  int checks = 0;
  int errors = 0;

  awaiba_frame_tx #(.DW(DW), .LINE_LEN(LL), .LINES(NL), .GAP(G)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync       (sync),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          s;
    logic          vin;
    logic [DW-1:0] din;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          ero;
    logic          eb;
    logic          efd;
  } vec_t;

  function automatic vec_t mk(input int s, input int vin, input int din, input int rdy,
                              input int ev, input int ed, input int ero, input int eb,
                              input int efd);
    vec_t v;
    v.s = 1'(s); v.vin = 1'(vin); v.din = DW'(din); v.rdy = 1'(rdy);
    v.ev = 1'(ev); v.ed = DW'(ed); v.ero = 1'(ero); v.eb = 1'(eb); v.efd = 1'(efd);
    return v;
  endfunction

  // Expected output word: external stream is 0..7 in order; pattern is line+index.
  function automatic int exp_word(input int n);
    return PAT ? (n / LL) + (n % LL) : n;
  endfunction

  vec_t tbl[19];

  // Streams one frame and checks it against a transaction-level model.
  // mode 0: all ready; 1: ready toggles; 2: valid_in stall; 3: random.
  // resync re-asserts sync during line 1; abort_at>0 pulls reset after that many words.
  task automatic run_frame(input int mode, input bit resync, input int abort_at);
    logic [DW-1:0] q[$];
    logic [DW-1:0] held_data = '0;
    logic [DW-1:0] exp_d;
    bit held = 1'b0;
    bit gap_pending = 1'b0;
    int words = 0, fds = 0, last_xfer = -1, fd_cyc = -1, cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      sync = (cyc == 0) || (resync && words >= int'(LL) + 1 && words < int'(LL) + 3);
      case (mode)
        0: begin valid_in = 1'b1; ready = 1'b1; end
        1: begin valid_in = 1'b1; ready = (cyc % 2 == 0); end
        2: begin valid_in = !(cyc >= 3 && cyc < 8); ready = 1'b1; end
        default: begin valid_in = ($urandom_range(0, 3) != 0); ready = ($urandom_range(0, 2) != 0); end
      endcase
      data_in = DW'($urandom);
      @(negedge clk);
      if (held) begin
        check("hold_valid", valid, 1);
        check("hold_data", data, held_data);
      end
      if (valid && !ready) check("ro_while_stalled", ready_out, 0);
      if (!PAT && mode == 2 && cyc == 6) check("stall_valid_drop", valid, 0);
      if (fd_cyc < 0 && cyc >= 1) check("busy_in_frame", busy, 1);
      if (valid && ready) begin
        if (PAT) exp_d = DW'(exp_word(words));
        else if (q.size() == 0) begin
          exp_d = ~data;
          $display("FAIL scoreboard_empty: output word %0d with nothing accepted", words);
        end else exp_d = q.pop_front();
        check("word", data, exp_d);
        words++;
        if (words % LL == 0) begin
          last_xfer = cyc;
          gap_pending = (words < int'(LL * NL));
        end
      end
      if (valid_in && ready_out) q.push_back(data_in);
      if (gap_pending && ready_out) begin
        check("gap_len", cyc - last_xfer, G + 1);
        gap_pending = 1'b0;
      end
      if (frame_done) begin
        fds++;
        check("done_latency", cyc - last_xfer, G + 1);
        check("words_at_done", words, LL * NL);
        fd_cyc = cyc;
      end
      if (fd_cyc >= 0 && cyc > fd_cyc) begin
        check("idle_busy", busy, 0);
        check("idle_valid", valid, 0);
        check("idle_ro", ready_out, 0);
        check("idle_fd", frame_done, 0);
      end
      held = valid && !ready;
      held_data = data;
      if (abort_at > 0 && words == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ro", ready_out, 0);
        check("abort_fd", frame_done, 0);
        sync = 1'b0; valid_in = 1'b0; ready = 1'b0;
        return;
      end
      if (fd_cyc >= 0 && cyc >= fd_cyc + 3) break;
      cyc++;
    end
    sync = 1'b0; valid_in = 1'b0; ready = 1'b0;
    check("frame_words", words, LL * NL);
    check("frame_done_count", fds, 1);
    if (!PAT) check("leftover_words", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Line 0 on cycles 1..5, gap 6..8, line 1 on 9..13, gap 14..16, done 17.
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tbl[1 + i] = mk(0, 1, i,     1, i > 0, exp_word(i - 1),     1, 1, 0);
      tbl[9 + i] = mk(0, 1, 4 + i, 1, i > 0, exp_word(4 + i - 1), 1, 1, 0);
    end
    tbl[5]  = mk(0, 1, 0, 1, 1, exp_word(3), 0, 1, 0);
    tbl[13] = mk(0, 1, 0, 1, 1, exp_word(7), 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tbl[6 + i]  = mk(0, 1, 0, 1, 0, 0, 0, 1, 0);
      tbl[14 + i] = mk(0, 1, 0, 1, 0, 0, 0, 1, 0);
    end
    tbl[17] = mk(0, 1, 0, 1, 0, 0, 0, 1, 1);
    tbl[18] = mk(0, 1, 0, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_ro", ready_out, 0);
    check("reset_busy", busy, 0);
    check("reset_fd", frame_done, 0);
    check("reset_data", data, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      sync = tbl[k].s; valid_in = tbl[k].vin; data_in = tbl[k].din; ready = tbl[k].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", k), valid, tbl[k].ev);
      if (tbl[k].ev) check($sformatf("tbl%0d_data", k), data, tbl[k].ed);
      check($sformatf("tbl%0d_ro", k), ready_out, tbl[k].ero);
      check($sformatf("tbl%0d_busy", k), busy, tbl[k].eb);
      check($sformatf("tbl%0d_fd", k), frame_done, tbl[k].efd);
    end
    @(posedge clk); #1;
    sync = 1'b0; valid_in = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);

    run_frame(1, 1'b0, 0);
    run_frame(2, 1'b0, 0);
    run_frame(0, 1'b1, 0);

    // Abort in line 1, then a fresh frame must start from line 0.
    run_frame(0, 1'b0, int'(LL) + 2);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 5; r++) run_frame(3, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
